ram_wr_seq: RTL and testbench
=============================

RAM_WR_SEQ -- requirements
Module: ram_wr_seq

Interface
REQ-001 The block SHALL have parameter DEPTH, default 14, meaning number of writable entries (legal 1..16).
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning data word width.
REQ-003 The block SHALL have port CP, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: write data present.
REQ-006 The block SHALL have port in_data, input, DATA_W bits: word to store.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-008 The block SHALL have port clr, input, 1 bit: restart the write sequence.
REQ-009 The block SHALL have port rd_en, input, 1 bit: read request.
REQ-010 The block SHALL have port rd_addr, input, 4 bits: read address.
REQ-011 The block SHALL have port rd_data, output, DATA_W bits: registered read data.
REQ-012 The block SHALL have port rd_valid, output, 1 bit: rd_data holds the result of the previous-cycle request.
REQ-013 The block SHALL have port wr_addr, output, 4 bits: address of the next write.
REQ-014 The block SHALL have port count, output, 5 bits: number of stored words.
REQ-015 The block SHALL have port full, output, 1 bit: count equals DEPTH.

Function
REQ-016 A write SHALL be accepted on a rising CP when in_valid=1, in_ready=1, clr=0 and RST=0; in_data is stored at wr_addr, then wr_addr increments and count increments.
REQ-017 The FSM SHALL have states EMPTY, FILL and FULL.
- EMPTY->FILL on the first accept.
- FILL->FULL on the accept that makes count=DEPTH.
- FULL holds until clr or RST.
- DEPTH=1: EMPTY->FULL directly.
REQ-018 full SHALL be 1 exactly in state FULL, and it SHALL be registered.
REQ-019 clr=1 SHALL, on the next edge, set wr_addr=0, count=0 and state EMPTY; memory contents are retained.
REQ-020 clr SHALL win over a simultaneous write; that write is dropped.
REQ-021 rd_en=1 at an edge SHALL yield rd_data and rd_valid=1 after the edge (1-cycle latency); rd_en=0 SHALL give rd_valid=0, and rd_data SHALL hold its last value.
REQ-022 rd_addr>=DEPTH SHALL return rd_data=0, with rd_valid=1.
REQ-023 A read and a write to the same address in the same cycle SHALL return the old contents (read-before-write).
REQ-024 Memory SHALL NOT be reset; reading an entry never written is unspecified and unchecked.
REQ-025 Reads SHALL be independent of state, clr and writes.

Reset
REQ-026 RST=1 at an edge SHALL set: state EMPTY, wr_addr=0, count=0, full=0, in_ready=1, rd_valid=0, rd_data=0.
REQ-027 RST SHALL override clr, in_valid and rd_en in the same cycle; the write and read in that cycle are dropped.
REQ-028 Reset mid-sequence SHALL restart writes at address 0 on the first accept after RST deasserts.

Configuration
REQ-029 Macro RAM_WR_WRAP_EN SHALL select overwrite-on-full behaviour.
REQ-030 Without RAM_WR_WRAP_EN: in_ready=!full, and in_valid in FULL is ignored, with no state or memory change.
REQ-031 With RAM_WR_WRAP_EN:
- in_ready is constantly 1 outside reset.
- In FULL, writes continue at wr_addr, and wr_addr wraps from DEPTH-1 to 0.
- count saturates at DEPTH, and full stays 1.
REQ-032 In both builds, wr_addr SHALL wrap from DEPTH-1 to 0 on the accept that fills the last entry.

Verification
REQ-033 Fill test: after RST, write 0x10..0x1D over 14 cycles -> full=1 after the 14th edge, count=14, wr_addr=0; the 15th word 0xFF is rejected (no-wrap build), and read addr 0 -> 0x10.
REQ-034 Read latency test: rd_en=1 with rd_addr=3 at edge N -> rd_valid=1 and rd_data=0x13 after edge N; rd_en=0 at edge N+1 -> rd_valid=0 after edge N+1.
REQ-035 Collision test: write 0xAA to addr 5 and read addr 5 in the same cycle (old value 0x15) -> rd_data=0x15; the next read -> 0xAA.
REQ-036 Clear test: write 3 words, then clr together with in_valid (data 0x77) -> count=0, wr_addr=0, EMPTY; the next accept is stored at addr 0, and 0x77 is not stored.
REQ-037 Out-of-range test: read addr 14 or 15 -> rd_data=0x00, rd_valid=1.
REQ-038 Wrap test (RAM_WR_WRAP_EN, DEPTH=14): 15 writes 0x10..0x1E -> addr 0 reads 0x1E, count=14, full=1, in_ready=1.

Source files
------------

// File: rtl/ram_wr_seq.sv
// ----------------------------------------------------------------------------
// ram_wr_seq
// Sequential-write RAM. Incoming words are stored at consecutive addresses
// starting at 0. A small FSM (EMPTY / FILL / FULL) tracks the fill level.
// Reads are random-access with a registered result one cycle after the request.
//
// Optional feature: define RAM_WR_WRAP_EN to keep accepting writes when full.
// New words then overwrite the oldest entries, and wr_addr wraps around.
// Without the macro, the block stops accepting writes once it is full.
//
// Parameters
//   DEPTH   number of writable entries (1..16)
//   DATA_W  data word width
//
// Ports
//   CP        clock; all state changes on the rising edge
//   RST       synchronous active-high reset
//   in_valid  write data present
//   in_data   word to store
//   in_ready  the block accepts a word this cycle
//   clr       restart the write sequence (memory contents kept)
//   rd_en     read request
//   rd_addr   read address
//   rd_data   registered read data
//   rd_valid  rd_data holds the result of the previous-cycle request
//   wr_addr   address of the next write
//   count     number of stored words
//   full      count equals DEPTH (registered)
// ----------------------------------------------------------------------------
module ram_wr_seq #(
  parameter int DEPTH  = 14,
  parameter int DATA_W = 8
) (
  input  logic              CP,
  input  logic              RST,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              clr,
  input  logic              rd_en,
  input  logic [3:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [3:0]        wr_addr,
  output logic [4:0]        count,
  output logic              full
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [4:0] DEPTH_C = 5'(DEPTH);
  localparam logic [3:0] LAST_C  = 4'(DEPTH - 1);

  state_t            state;
  state_t            next_state;
  logic [3:0]        next_addr;
  logic [4:0]        next_count;
  logic [4:0]        count_inc;
  logic              accept;
  logic              rd_in_range;
  logic [DATA_W-1:0] mem [DEPTH];

`ifdef RAM_WR_WRAP_EN
  assign in_ready = 1'b1;
`else
  assign in_ready = ~full;
`endif

  // Reset and clear both suppress a write presented in the same cycle.
  assign accept      = in_valid & in_ready & ~clr & ~RST;
  assign count_inc   = count + 5'd1;
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_C);

  // Next-state logic for the fill FSM, write pointer and word counter.
  always_comb begin
    next_state = state;
    next_addr  = wr_addr;
    next_count = count;
    if (clr) begin
      next_state = EMPTY;
      next_addr  = 4'd0;
      next_count = 5'd0;
    end else if (accept) begin
      next_addr  = (wr_addr == LAST_C) ? 4'd0 : (wr_addr + 4'd1);
      // The count saturates because overwrite mode keeps writing while FULL.
      next_count = (count == DEPTH_C) ? count : count_inc;
      case (state)
        EMPTY:   next_state = (count_inc == DEPTH_C) ? FULL : FILL;
        FILL:    next_state = (count_inc == DEPTH_C) ? FULL : FILL;
        FULL:    next_state = FULL;
        default: next_state = EMPTY;
      endcase
    end else begin
      next_state = state;
    end
  end

  // State, pointer, counter and full-flag registers.
  always_ff @(posedge CP) begin
    if (RST) begin
      state   <= EMPTY;
      wr_addr <= 4'd0;
      count   <= 5'd0;
      full    <= 1'b0;
    end else begin
      state   <= next_state;
      wr_addr <= next_addr;
      count   <= next_count;
      full    <= (next_state == FULL);
    end
  end

  // Storage array; not reset, so it keeps its contents across clr and RST.
  always_ff @(posedge CP) begin
    if (accept) begin
      mem[wr_addr] <= in_data;
    end
  end

  // Registered read port. It samples the pre-edge contents, which gives
  // read-before-write behaviour on a same-address collision.
  always_ff @(posedge CP) begin
    if (RST) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (rd_en) begin
      rd_valid <= 1'b1;
      rd_data  <= rd_in_range ? mem[rd_addr] : '0;
    end else begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_wr_seq.sv
// ----------------------------------------------------------------------------
// tb_ram_wr_seq
// Directed self-checking bench for ram_wr_seq (DEPTH=14, DATA_W=8).
// Each scenario task drives its own stimulus and compares outputs sampled
// 1 time unit after the rising clock edge against hand-computed values.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ram_wr_seq;

  logic       CP;
  logic       RST;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       clr;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [3:0] wr_addr;
  logic [4:0] count;
  logic       full;

  int vectors;
  int miscompares;

  ram_wr_seq #(.DEPTH(14), .DATA_W(8)) dut (
    .CP       (CP),
    .RST      (RST),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .clr      (clr),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .wr_addr  (wr_addr),
    .count    (count),
    .full     (full)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  // Advance one clock edge, then move away from the edge before sampling.
  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_data  = 8'h00;
    clr      = 1'b0;
    rd_en    = 1'b0;
    rd_addr  = 4'd0;
  endtask

  task automatic write_word(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic read_word(input logic [3:0] a);
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    rd_en   = 1'b0;
  endtask

  // Reset while every other control is active: nothing may be written or read.
  task automatic test_reset();
    RST = 1'b1; in_valid = 1'b1; in_data = 8'hEE; clr = 1'b1; rd_en = 1'b1; rd_addr = 4'd0;
    tick();
    tick();
    vectors++;
    if (count !== 5'd0)    begin miscompares++; $display("FAIL reset_count: got %0d expected 0", count); end
    vectors++;
    if (wr_addr !== 4'd0)  begin miscompares++; $display("FAIL reset_wr_addr: got %0d expected 0", wr_addr); end
    vectors++;
    if (full !== 1'b0)     begin miscompares++; $display("FAIL reset_full: got %b expected 0", full); end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    vectors++;
    if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    vectors++;
    if (rd_data !== 8'h00) begin miscompares++; $display("FAIL reset_rd_data: got %0h expected 00", rd_data); end
    RST = 1'b0;
    idle_inputs();
  endtask

  // Fill all 14 entries with 0x10..0x1D and check counting and the full flag.
  // Without overwrite mode, a 15th word must be refused. With overwrite mode,
  // that word lands at address 0.
  task automatic test_fill();
    for (int i = 0; i < 14; i++) begin
      write_word(8'h10 + 8'(i));
      vectors++;
      if (count !== 5'(i + 1)) begin miscompares++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, i + 1); end
      vectors++;
      if (full !== (i == 13)) begin miscompares++; $display("FAIL fill_full[%0d]: got %b expected %b", i, full, (i == 13)); end
    end
    vectors++;
    if (wr_addr !== 4'd0) begin miscompares++; $display("FAIL fill_wr_addr_wrap: got %0d expected 0", wr_addr); end
`ifdef RAM_WR_WRAP_EN
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL wrap_in_ready: got %b expected 1", in_ready); end
    write_word(8'h1E);
    vectors++;
    if (count !== 5'd14)   begin miscompares++; $display("FAIL wrap_count: got %0d expected 14", count); end
    vectors++;
    if (full !== 1'b1)     begin miscompares++; $display("FAIL wrap_full: got %b expected 1", full); end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL wrap_in_ready2: got %b expected 1", in_ready); end
    vectors++;
    if (wr_addr !== 4'd1)  begin miscompares++; $display("FAIL wrap_wr_addr: got %0d expected 1", wr_addr); end
    read_word(4'd0);
    vectors++;
    if (rd_data !== 8'h1E) begin miscompares++; $display("FAIL wrap_read0: got %0h expected 1e", rd_data); end
`else
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
    write_word(8'hFF);
    vectors++;
    if (count !== 5'd14)   begin miscompares++; $display("FAIL reject_count: got %0d expected 14", count); end
    vectors++;
    if (wr_addr !== 4'd0)  begin miscompares++; $display("FAIL reject_wr_addr: got %0d expected 0", wr_addr); end
    vectors++;
    if (full !== 1'b1)     begin miscompares++; $display("FAIL reject_full: got %b expected 1", full); end
    read_word(4'd0);
    vectors++;
    if (rd_data !== 8'h10) begin miscompares++; $display("FAIL fill_read0: got %0h expected 10", rd_data); end
`endif
  endtask

  // One-cycle read latency, rd_valid dropping, and rd_data holding its value.
  task automatic test_read_latency();
    rd_en = 1'b1; rd_addr = 4'd3;
    tick();
    vectors++;
    if (rd_valid !== 1'b1) begin miscompares++; $display("FAIL lat_rd_valid: got %b expected 1", rd_valid); end
    vectors++;
    if (rd_data !== 8'h13) begin miscompares++; $display("FAIL lat_rd_data: got %0h expected 13", rd_data); end
    rd_en = 1'b0; rd_addr = 4'd7;
    tick();
    vectors++;
    if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL lat_rd_valid_off: got %b expected 0", rd_valid); end
    vectors++;
    if (rd_data !== 8'h13) begin miscompares++; $display("FAIL lat_rd_data_hold: got %0h expected 13", rd_data); end
  endtask

  // Addresses at and beyond DEPTH read as zero but still report valid.
  task automatic test_out_of_range();
    read_word(4'd14);
    vectors++;
    if (rd_data !== 8'h00 || rd_valid !== 1'b1) begin miscompares++; $display("FAIL oor_14: got data %0h valid %b expected 00/1", rd_data, rd_valid); end
    read_word(4'd9);
    vectors++;
    if (rd_data !== 8'h19) begin miscompares++; $display("FAIL oor_in_range9: got %0h expected 19", rd_data); end
    read_word(4'd15);
    vectors++;
    if (rd_data !== 8'h00 || rd_valid !== 1'b1) begin miscompares++; $display("FAIL oor_15: got data %0h valid %b expected 00/1", rd_data, rd_valid); end
  endtask

  // A same-cycle read and write to address 5 returns the old value.
  task automatic test_collision();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 5; i++) write_word(8'h10 + 8'(i));
    vectors++;
    if (wr_addr !== 4'd5) begin miscompares++; $display("FAIL coll_wr_addr: got %0d expected 5", wr_addr); end
    in_valid = 1'b1; in_data = 8'hAA; rd_en = 1'b1; rd_addr = 4'd5;
    tick();
    idle_inputs();
    vectors++;
    if (rd_data !== 8'h15) begin miscompares++; $display("FAIL coll_old: got %0h expected 15", rd_data); end
    read_word(4'd5);
    vectors++;
    if (rd_data !== 8'hAA) begin miscompares++; $display("FAIL coll_new: got %0h expected aa", rd_data); end
  endtask

  // When clr and a write arrive together, clr wins and the write is dropped.
  task automatic test_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    write_word(8'h31);
    write_word(8'h32);
    write_word(8'h33);
    vectors++;
    if (count !== 5'd3) begin miscompares++; $display("FAIL clr_pre_count: got %0d expected 3", count); end
    clr = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    tick();
    idle_inputs();
    vectors++;
    if (count !== 5'd0 || wr_addr !== 4'd0 || full !== 1'b0) begin miscompares++; $display("FAIL clr_state: got count %0d addr %0d full %b expected 0/0/0", count, wr_addr, full); end
    write_word(8'h44);
    vectors++;
    if (count !== 5'd1 || wr_addr !== 4'd1) begin miscompares++; $display("FAIL clr_next_accept: got count %0d addr %0d expected 1/1", count, wr_addr); end
    read_word(4'd0);
    vectors++;
    if (rd_data !== 8'h44) begin miscompares++; $display("FAIL clr_read0: got %0h expected 44", rd_data); end
    read_word(4'd3);
    vectors++;
    if (rd_data !== 8'h13) begin miscompares++; $display("FAIL clr_dropped_77: got %0h expected 13", rd_data); end
  endtask

  // Reset in mid-sequence drops the concurrent write and read.
  // Writing then restarts at address 0.
  task automatic test_reset_mid();
    write_word(8'h88);
    vectors++;
    if (wr_addr !== 4'd2) begin miscompares++; $display("FAIL mid_pre_addr: got %0d expected 2", wr_addr); end
    RST = 1'b1; in_valid = 1'b1; in_data = 8'h55; rd_en = 1'b1; rd_addr = 4'd1;
    tick();
    RST = 1'b0;
    idle_inputs();
    vectors++;
    if (count !== 5'd0 || wr_addr !== 4'd0 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin
      miscompares++; $display("FAIL mid_reset: got count %0d addr %0d rv %b rd %0h expected 0/0/0/00", count, wr_addr, rd_valid, rd_data);
    end
    write_word(8'h66);
    read_word(4'd0);
    vectors++;
    if (rd_data !== 8'h66) begin miscompares++; $display("FAIL mid_restart0: got %0h expected 66", rd_data); end
    read_word(4'd2);
    vectors++;
    if (rd_data !== 8'h33) begin miscompares++; $display("FAIL mid_dropped_55: got %0h expected 33", rd_data); end
    read_word(4'd1);
    vectors++;
    if (rd_data !== 8'h88) begin miscompares++; $display("FAIL mid_kept1: got %0h expected 88", rd_data); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    RST         = 1'b1;
    idle_inputs();
    test_reset();
    test_fill();
    test_read_latency();
    test_out_of_range();
    test_collision();
    test_clear();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
